// File: rtl/apb_timer_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_timer_slave
// Description : APB3 down-counter timer with 8-bit prescaler, EXTIN edge count
//               enable, periodic/one-shot modes and a level interrupt.
//               Optional single wait state per transfer: APB_TIMER_WAIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_timer_slave #(
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 32
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 PCLKEN,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic [DATAWIDTH-1:0] PWDATA,
  output logic [DATAWIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  input  logic                 EXTIN,
  output logic                 TIMERINT
);

  localparam logic [2:0] c_OFF_CTRL     = 3'd0;
  localparam logic [2:0] c_OFF_VALUE    = 3'd1;
  localparam logic [2:0] c_OFF_RELOAD   = 3'd2;
  localparam logic [2:0] c_OFF_INTSTAT  = 3'd3;
  localparam logic [2:0] c_OFF_PRESCALE = 3'd4;

  // Register state
  logic                 r_en;
  logic                 r_extsel;
  logic                 r_irqen;
  logic                 r_oneshot;
  logic [DATAWIDTH-1:0] r_value;
  logic [DATAWIDTH-1:0] r_reload;
  logic                 r_intstat;
  logic [7:0]           r_prescale;
  logic [7:0]           r_presc_cnt;

  // EXTIN synchroniser and edge detect
  logic                 r_ext_meta;
  logic                 r_ext_sync;
  logic                 r_ext_prev;

  // Bus decode
  logic [2:0]           w_offset;
  logic                 w_mapped;
  logic                 w_setup;
  logic                 w_access;
  logic                 w_wr;
  logic                 w_capture;
  logic                 w_wr_ctrl;
  logic                 w_wr_value;
  logic                 w_wr_reload;
  logic                 w_wr_intstat;
  logic                 w_wr_prescale;
  logic [DATAWIDTH-1:0] w_rdata;
  logic                 w_unused_addr;

  // Counting
  logic                 w_ext_rise;
  logic                 w_en_clear;
  logic                 w_en_rise;
  logic                 w_tick;
  logic                 w_presc_hit;
  logic                 w_dec;
  logic                 w_expire;

  assign w_offset      = PADDR[4:2];
  assign w_mapped      = (w_offset <= c_OFF_PRESCALE);
  assign w_unused_addr = ^{PADDR[ADDRWIDTH-1:5], PADDR[1:0]};

  assign w_setup  = PSEL & ~PENABLE & PCLKEN;
  assign w_access = PSEL & PENABLE & PREADY & PCLKEN;
  assign w_wr     = w_access & PWRITE;

  assign w_wr_ctrl     = w_wr & (w_offset == c_OFF_CTRL);
  assign w_wr_value    = w_wr & (w_offset == c_OFF_VALUE);
  assign w_wr_reload   = w_wr & (w_offset == c_OFF_RELOAD);
  assign w_wr_intstat  = w_wr & (w_offset == c_OFF_INTSTAT);
  assign w_wr_prescale = w_wr & (w_offset == c_OFF_PRESCALE);

  always_comb begin
    w_rdata = '0;
    case (w_offset)
      c_OFF_CTRL:     w_rdata = {{(DATAWIDTH-4){1'b0}}, r_oneshot, r_irqen, r_extsel, r_en};
      c_OFF_VALUE:    w_rdata = r_value;
      c_OFF_RELOAD:   w_rdata = r_reload;
      c_OFF_INTSTAT:  w_rdata = {{(DATAWIDTH-1){1'b0}}, r_intstat};
      c_OFF_PRESCALE: w_rdata = {{(DATAWIDTH-8){1'b0}}, r_prescale};
      default:        w_rdata = '0;
    endcase
  end

`ifdef APB_TIMER_WAIT_EN
  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_WAIT  = 1'b1
  } apb_state_t;

  apb_state_t r_state;
  apb_state_t w_state_next;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= ST_READY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Read data and error are captured in the wait cycle so they are valid with PREADY.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      ST_READY: begin
        if (w_setup) begin
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (PSEL & PENABLE & PCLKEN) begin
          w_state_next = ST_READY;
          w_capture    = 1'b1;
        end
      end
      default: w_state_next = ST_READY;
    endcase
  end

  assign PREADY = (r_state == ST_READY);
`else
  assign w_capture = w_setup;
  assign PREADY    = 1'b1;
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else if (w_capture) begin
      PSLVERR <= ~w_mapped;
      if (!PWRITE) begin
        PRDATA <= w_rdata;
      end
    end
  end

  // The synchroniser runs every HCLK; only the edge reference is frozen by PCLKEN,
  // so an edge arriving while PCLKEN=0 is still seen on the next enabled cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_ext_meta <= 1'b0;
      r_ext_sync <= 1'b0;
      r_ext_prev <= 1'b0;
    end else begin
      r_ext_meta <= EXTIN;
      r_ext_sync <= r_ext_meta;
      if (PCLKEN) begin
        r_ext_prev <= r_ext_sync;
      end
    end
  end

  assign w_ext_rise  = r_ext_sync & ~r_ext_prev;
  assign w_en_clear  = w_wr_ctrl & ~PWDATA[0];
  assign w_en_rise   = w_wr_ctrl & PWDATA[0] & ~r_en;
  assign w_tick      = PCLKEN & r_en & ~w_en_clear & (r_extsel ? w_ext_rise : 1'b1);
  assign w_presc_hit = (r_presc_cnt == r_prescale);
  assign w_dec       = w_tick & w_presc_hit;
  assign w_expire    = w_dec & (r_value == '0);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_en      <= 1'b0;
      r_extsel  <= 1'b0;
      r_irqen   <= 1'b0;
      r_oneshot <= 1'b0;
    end else if (w_wr_ctrl) begin
      {r_oneshot, r_irqen, r_extsel, r_en} <= PWDATA[3:0];
    end else if (w_expire & r_oneshot) begin
      r_en <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_prescale <= 8'd0;
      r_reload   <= '0;
    end else begin
      if (w_wr_prescale) begin
        r_prescale <= PWDATA[7:0];
      end
      if (w_wr_reload) begin
        r_reload <= PWDATA;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_presc_cnt <= 8'd0;
    end else if (w_wr_prescale | w_wr_value | w_en_rise) begin
      r_presc_cnt <= 8'd0;
    end else if (w_tick) begin
      r_presc_cnt <= w_presc_hit ? 8'd0 : r_presc_cnt + 8'd1;
    end
  end

  // A bus write to VALUE takes priority over a decrement on the same edge.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_value <= '0;
    end else if (w_wr_value) begin
      r_value <= PWDATA;
    end else if (w_dec) begin
      if (r_value != '0) begin
        r_value <= r_value - 1'b1;
      end else if (!r_oneshot) begin
        r_value <= r_reload;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_intstat <= 1'b0;
    end else if (w_expire) begin
      r_intstat <= 1'b1;
    end else if (w_wr_intstat & PWDATA[0]) begin
      r_intstat <= 1'b0;
    end
  end

  assign TIMERINT = r_intstat & r_irqen;

endmodule
`default_nettype wire
